multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the RV32I subset datapath, replacing the single-cycle decoder. One shared memory port serves fetch and data. A Moore FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, waits on a memory-ready handshake, and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the datapath muxes, ALU, register file and memory port.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states hold until `mem_ready`; 0 = every memory access takes exactly one cycle and `mem_ready` is ignored.
- MAX_WAIT, 16: wait-cycle limit per memory access before trap; 0 disables the watchdog.
- WAIT_W, 5: wait-counter width; must satisfy MAX_WAIT < 2**WAIT_W.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- zero  in  1  ALU zero flag, combinational.
- mem_ready  in  1  memory access completes this cycle.
- pc_write, ir_write, reg_write  out  1  write enables.
- mem_read, mem_write  out  1  memory strobes, held high until completion.
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_size  out  2  00 = byte, 10 = word.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = rs1, 10 = oldPC.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = 4, 10 = imm.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_ctrl  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101.
- illegal, mem_timeout  out  1  sticky error flags.
- state_o  out  4  current state, debug only.

## Operation
- Supported instructions:
  - R-type: add, sub (funct7[5]=1), and, or, sll, srl.
  - I-type: addi, ori.
  - Loads: lb, lw. Stores: sb, sw.
  - Branches: beq, bne.
  - Any other opcode/funct3 combination is illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, ADD.
  - On completion: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
- DECODE:
  - alu_src_a=10, alu_src_b=10, ADD: branch target is latched into ALUOut.
  - Next state by opcode: R-type → EXEC_R; I-type → EXEC_I; load/store → MEM_ADDR; branch → BRANCH.
  - Illegal encoding → TRAP and set `illegal`.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_ctrl from funct3/funct7; then WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10; ADD for addi, OR for ori; then WB_ALU.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, ADD; load → MEM_RD, store → MEM_WR.
- MEM_RD:
  - mem_read=1, i_or_d=1, mem_size from funct3.
  - On completion go to WB_MEM. Byte loads are sign-extended by the datapath.
- MEM_WR: mem_write=1, i_or_d=1, mem_size from funct3; on completion go to FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0; then FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1; then FETCH.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, SUB, pc_src=1.
  - pc_write = (beq & zero) | (bne & ~zero); then FETCH.
- TRAP: every enable and strobe is 0; the FSM stays in TRAP until rst_n.
- Outputs not listed for a state are 0, and alu_ctrl defaults to ADD.

## Timing
- Completion of an access is defined as:
  - MEM_HANDSHAKE=1: the cycle in which `mem_ready`=1.
  - MEM_HANDSHAKE=0: the first cycle of the access.
- Write enables that depend on completion (ir_write and pc_write in FETCH) are gated combinationally by the completion condition.
- Cycle counts with zero-wait memory:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Increments every cycle spent in FETCH, MEM_RD or MEM_WR without completion.
  - Clears on completion and on every state change.
  - If the counter equals MAX_WAIT with no completion (MAX_WAIT≠0), the next state is TRAP and `mem_timeout` is set.
  - `mem_ready` arriving in the same cycle as the limit wins: the access completes and no trap occurs.
- `mem_ready` outside memory states is ignored.
- Reset:
  - While rst_n=0: state=FETCH, counter=0, illegal=0, mem_timeout=0, and all outputs are forced to 0.
  - After reset is released, the first edge begins FETCH.
  - An asynchronous reset mid-access aborts the access immediately; no partial write strobes remain.

## Structure
- Package `riscv_ctrl_pkg`: opcode constants, ALU encodings, state enum (4 bits), mem_size codes.
- Sub-module `alu_decoder`: combinational mapping of funct3/funct7/op-class to alu_ctrl and legality. Reused by the pipelined core later.

## Test plan
- add x3,x1,x2 (0x002081B3), zero-wait memory → states FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1 only in cycle 4; alu_ctrl=0001 for sub (0x402081B3).
- lb x5,0(x1) with mem_ready delayed 3 cycles in MEM_RD → WB_MEM entered 4 cycles after MEM_RD entry; mem_size=00; load latency 8 cycles total.
- bne with zero=0 → pc_write=1, pc_src=1 in BRANCH; with zero=1 → pc_write=0; beq mirrored.
- Opcode 0x7F in DECODE → TRAP next cycle; illegal=1; no further strobes for 20 cycles.
- MAX_WAIT=4, mem_ready held 0 in FETCH → TRAP after 5 FETCH cycles, mem_timeout=1; mem_ready=1 on the 5th cycle → normal DECODE.
- rst_n pulsed low during MEM_WR with mem_write=1 → mem_write drops asynchronously; state_o=FETCH after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multicycle control unit: opcodes,
// ALU operations, datapath mux selects, memory sizes and FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_NONE   = 3'd5
  } op_class_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  // Map the major opcode to its instruction class.
  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:  return CLS_R;
      OP_ITYPE:  return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

  // Only byte (funct3=000) and word (funct3=010) accesses are legal.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1] ? SIZE_WORD : SIZE_BYTE;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational decode of op-class/funct3/funct7 into an ALU operation and
// a legality flag. Kept free of FSM state so the pipelined core can reuse it.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  op_class_e   op_class_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [3:0]  alu_ctrl_o,
  output logic        legal_o
);

  // Legal encodings of the supported subset and the ALU op each needs.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b0;
    case (op_class_i)
      CLS_R: begin
        if (funct7_i == 7'b0000000) begin
          case (funct3_i)
            3'b000: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b1; end
            3'b111: begin alu_ctrl_o = ALU_AND; legal_o = 1'b1; end
            3'b110: begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
            3'b001: begin alu_ctrl_o = ALU_SLL; legal_o = 1'b1; end
            3'b101: begin alu_ctrl_o = ALU_SRL; legal_o = 1'b1; end
            default: legal_o = 1'b0;
          endcase
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          alu_ctrl_o = ALU_SUB;
          legal_o    = 1'b1;
        end
      end
      CLS_I: begin
        case (funct3_i)
          3'b000: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b1; end
          3'b110: begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
          default: legal_o = 1'b0;
        endcase
      end
      CLS_LOAD, CLS_STORE: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = (funct3_i == 3'b000) || (funct3_i == 3'b010);
      end
      CLS_BRANCH: begin
        alu_ctrl_o = ALU_SUB;
        legal_o    = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE);
      end
      default: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I-subset datapath. One shared memory
// port serves fetch and data; each instruction walks FETCH/DECODE/EXEC/MEM/WB.
//
// Memory handshake: mem_read/mem_write are the request and stay high for the
// whole access; the access completes in the cycle mem_ready=1 (or in its first
// cycle when MEM_HANDSHAKE=0). The wait counter traps an access that has not
// completed after MAX_WAIT wait cycles; mem_ready in the limit cycle still wins.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int          MEM_HANDSHAKE = 1,
  parameter int unsigned MAX_WAIT      = 16,
  parameter int unsigned WAIT_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic [1:0] mem_size,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_src,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  op_class_e         op_class;
  logic [3:0]        dec_alu_ctrl;
  logic              dec_legal;
  logic              done;
  logic              limit_hit;

  assign op_class  = classify(opcode);
  assign done      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign limit_hit = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT));

  alu_decoder u_alu_decoder (
    .op_class_i (op_class),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .alu_ctrl_o (dec_alu_ctrl),
    .legal_o    (dec_legal)
  );

  // Next state, wait counter and sticky error flags.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (done) begin
          if (state_q == S_FETCH)       state_d = S_DECODE;
          else if (state_q == S_MEM_RD) state_d = S_WB_MEM;
          else                          state_d = S_FETCH;
        end else if (limit_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          case (op_class)
            CLS_R:               state_d = S_EXEC_R;
            CLS_I:               state_d = S_EXEC_I;
            CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
            CLS_BRANCH:          state_d = S_BRANCH;
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I:            state_d = S_WB_ALU;
      S_MEM_ADDR:                    state_d = (op_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BRANCH:  state_d = S_FETCH;
      S_TRAP:                        state_d = S_TRAP;
      default:                       state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore control decode; completion gates the FETCH write enables, and every
  // output is forced low while reset is asserted so no strobe survives it.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_size   = SIZE_BYTE;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    pc_src     = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ir_write  = done;
        pc_write  = done;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctrl  = dec_alu_ctrl;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = dec_alu_ctrl;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        mem_size = size_of(funct3);
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        mem_size  = size_of(funct3);
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctrl  = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_size   = SIZE_BYTE;
      mem_to_reg = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      pc_src     = 1'b0;
      alu_ctrl   = ALU_ADD;
    end
  end

  assign illegal     = rst_n & illegal_q;
  assign mem_timeout = rst_n & timeout_q;
  assign state_o     = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a driver walks an instruction-level model
// through the expected state sequence, pushing one expected control vector
// per cycle; a monitor pops and compares on every falling edge.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int W = 24;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_BEQ = 4;
  localparam int K_BNE = 5;
  localparam int K_ILL = 6;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         kind;
    logic [3:0] alu;
    logic [1:0] size;
  } instr_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d;
  logic [1:0] mem_size;
  logic       mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b;
  logic       pc_src;
  logic [3:0] alu_ctrl;
  logic       illegal, mem_timeout;
  logic [3:0] state_o;

  multicycle_control #(
    .MEM_HANDSHAKE (1),
    .MAX_WAIT      (MAX_WAIT),
    .WAIT_W        (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .i_or_d      (i_or_d),
    .mem_size    (mem_size),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_ctrl    (alu_ctrl),
    .illegal     (illegal),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  instr_t itab[21];
  instr_t cur;
  bit     cur_zero;
  bit     m_illegal;
  bit     m_timeout;

  function automatic logic [W-1:0] got_vec();
    return {state_o, pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
            mem_size, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
            illegal, mem_timeout};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) required %h (state %0d)",
               name, got, got[W-1 -: 4], exp, exp[W-1 -: 4]);
    end
  endtask

  // Reference model: control outputs of one cycle from the instruction's
  // documented behaviour in the given state.
  function automatic logic [W-1:0] exp_vec(input state_e st, input bit ready);
    bit pcw, irw, rw, mr, mw, iod, m2r, pcs;
    logic [1:0] sz, sa, sb;
    logic [3:0] alu;
    pcw = 0; irw = 0; rw = 0; mr = 0; mw = 0; iod = 0; m2r = 0; pcs = 0;
    sz = 2'b00; sa = 2'b00; sb = 2'b00; alu = 4'b0000;
    case (st)
      S_FETCH:    begin mr = 1; sb = 2'b01; irw = ready; pcw = ready; end
      S_DECODE:   begin sa = 2'b10; sb = 2'b10; end
      S_EXEC_R:   begin sa = 2'b01; sb = 2'b00; alu = cur.alu; end
      S_EXEC_I:   begin sa = 2'b01; sb = 2'b10; alu = cur.alu; end
      S_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iod = 1; sz = cur.size; end
      S_MEM_WR:   begin mw = 1; iod = 1; sz = cur.size; end
      S_WB_ALU:   rw = 1;
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_BRANCH: begin
        sa = 2'b01; sb = 2'b00; alu = 4'b0001; pcs = 1;
        pcw = (cur.kind == K_BEQ) ? cur_zero : !cur_zero;
      end
      default: ;
    endcase
    return {st, pcw, irw, rw, mr, mw, iod, sz, m2r, sa, sb, pcs, alu, m_illegal, m_timeout};
  endfunction

  // driver tasks: each call covers exactly one clock cycle
  task automatic cycle(input state_e st, input bit ready);
    if (st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) mem_ready = ready;
    else mem_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(exp_vec(st, ready));
    @(posedge clk); #1;
  endtask

  task automatic mem_phase(input state_e st, input int w, output bit trapped);
    trapped = 0;
    for (int i = 0; i <= w; i++) begin
      cycle(st, i == w);
      if (i == MAX_WAIT && i != w) begin
        m_timeout = 1;
        trapped = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_illegal = 0;
    m_timeout = 0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      zero = 1'($urandom_range(0, 1));
      cycle(S_TRAP, 0);
    end
  endtask

  task automatic run_instr(input int idx, input int wf, input int wd, input bit z);
    bit tr;
    cur = itab[idx];
    opcode = cur.op;
    funct3 = cur.f3;
    funct7 = (cur.kind == K_R || cur.kind == K_ILL) ? cur.f7 : 7'($urandom);
    zero = z;
    cur_zero = z;
    mem_phase(S_FETCH, wf, tr);
    if (tr) return;
    cycle(S_DECODE, 0);
    case (cur.kind)
      K_R:  begin cycle(S_EXEC_R, 0); cycle(S_WB_ALU, 0); end
      K_I:  begin cycle(S_EXEC_I, 0); cycle(S_WB_ALU, 0); end
      K_LD: begin
        cycle(S_MEM_ADDR, 0);
        mem_phase(S_MEM_RD, wd, tr);
        if (!tr) cycle(S_WB_MEM, 0);
      end
      K_ST: begin
        cycle(S_MEM_ADDR, 0);
        mem_phase(S_MEM_WR, wd, tr);
      end
      K_BEQ, K_BNE: cycle(S_BRANCH, 0);
      default: m_illegal = 1;
    endcase
  endtask

  task automatic set_entry(input int i, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int kind, input logic [3:0] alu,
                           input logic [1:0] size);
    itab[i].op = op; itab[i].f3 = f3; itab[i].f7 = f7;
    itab[i].kind = kind; itab[i].alu = alu; itab[i].size = size;
  endtask

  // monitor: one output vector per clock cycle while expectations are queued
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("cycle%0d_op%h", cyc, opcode), got_vec(), e);
    end
  end

  initial begin
    bit tr;
    int guard;
    set_entry(0,  7'h33, 3'b000, 7'h00, K_R,   4'b0000, 2'b00); // add
    set_entry(1,  7'h33, 3'b000, 7'h20, K_R,   4'b0001, 2'b00); // sub
    set_entry(2,  7'h33, 3'b111, 7'h00, K_R,   4'b0010, 2'b00); // and
    set_entry(3,  7'h33, 3'b110, 7'h00, K_R,   4'b0011, 2'b00); // or
    set_entry(4,  7'h33, 3'b001, 7'h00, K_R,   4'b0100, 2'b00); // sll
    set_entry(5,  7'h33, 3'b101, 7'h00, K_R,   4'b0101, 2'b00); // srl
    set_entry(6,  7'h13, 3'b000, 7'h00, K_I,   4'b0000, 2'b00); // addi
    set_entry(7,  7'h13, 3'b110, 7'h00, K_I,   4'b0011, 2'b00); // ori
    set_entry(8,  7'h03, 3'b000, 7'h00, K_LD,  4'b0000, 2'b00); // lb
    set_entry(9,  7'h03, 3'b010, 7'h00, K_LD,  4'b0000, 2'b10); // lw
    set_entry(10, 7'h23, 3'b000, 7'h00, K_ST,  4'b0000, 2'b00); // sb
    set_entry(11, 7'h23, 3'b010, 7'h00, K_ST,  4'b0000, 2'b10); // sw
    set_entry(12, 7'h63, 3'b000, 7'h00, K_BEQ, 4'b0000, 2'b00); // beq
    set_entry(13, 7'h63, 3'b001, 7'h00, K_BNE, 4'b0000, 2'b00); // bne
    set_entry(14, 7'h7F, 3'b000, 7'h00, K_ILL, 4'b0000, 2'b00); // unknown opcode
    set_entry(15, 7'h33, 3'b101, 7'h20, K_ILL, 4'b0000, 2'b00); // sra
    set_entry(16, 7'h13, 3'b001, 7'h00, K_ILL, 4'b0000, 2'b00); // slli
    set_entry(17, 7'h03, 3'b001, 7'h00, K_ILL, 4'b0000, 2'b00); // lh
    set_entry(18, 7'h23, 3'b001, 7'h00, K_ILL, 4'b0000, 2'b00); // sh
    set_entry(19, 7'h63, 3'b100, 7'h00, K_ILL, 4'b0000, 2'b00); // blt
    set_entry(20, 7'h33, 3'b000, 7'h01, K_ILL, 4'b0000, 2'b00); // add, bad funct7

    rst_n = 1'b0;
    opcode = 7'h33; funct3 = 3'b000; funct7 = 7'h00; zero = 1'b0; mem_ready = 1'b0;
    m_illegal = 0; m_timeout = 0; cur = itab[0]; cur_zero = 0;
    @(posedge clk); #1;
    do_reset();

    // directed: add, sub, lb with three wait cycles, branches both ways
    run_instr(0, 0, 0, 0);
    run_instr(1, 0, 0, 0);
    run_instr(8, 0, 3, 0);
    run_instr(13, 0, 0, 0);
    run_instr(13, 0, 0, 1);
    run_instr(12, 0, 0, 0);
    run_instr(12, 0, 0, 1);
    // mem_ready arrives in the limit cycle: completes, no trap
    run_instr(0, MAX_WAIT, 0, 0);
    run_instr(9, 1, MAX_WAIT, 0);
    run_instr(11, 0, MAX_WAIT, 0);

    // random legal instruction stream
    for (int n = 0; n < 80; n++) begin
      run_instr($urandom_range(0, 13), $urandom_range(0, MAX_WAIT),
                $urandom_range(0, MAX_WAIT), 1'($urandom_range(0, 1)));
    end

    // illegal opcode 0x7F: trap, then quiet for 20 cycles
    run_instr(14, 0, 0, 0);
    trap_cycles(20);
    do_reset();
    for (int k = 15; k <= 20; k++) begin
      run_instr(k, $urandom_range(0, 2), 0, 0);
      trap_cycles(3);
      do_reset();
    end

    // fetch watchdog: no mem_ready for MAX_WAIT+1 cycles
    run_instr(0, MAX_WAIT + 1, 0, 0);
    trap_cycles(5);
    do_reset();
    // data-write watchdog
    run_instr(10, 0, MAX_WAIT + 3, 0);
    trap_cycles(3);
    do_reset();

    // asynchronous reset in the middle of a store
    cur = itab[11];
    opcode = cur.op; funct3 = cur.f3; funct7 = 7'($urandom); zero = 0; cur_zero = 0;
    mem_phase(S_FETCH, 0, tr);
    cycle(S_DECODE, 0);
    cycle(S_MEM_ADDR, 0);
    mem_ready = 1'b0;
    exp_q.push_back(exp_vec(S_MEM_WR, 0));
    #6;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_write", got_vec(), '0);
    @(posedge clk); #1;
    do_reset();
    run_instr(6, 0, 0, 0);
    run_instr(8, 2, 1, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
